// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
//   clk, rst                       clock, synchronous active-high reset
//   start, dividend, divisor       request and operands, sampled only when idle
//   busy, done                     in-progress flag, one-cycle result pulse
//   quotient, remainder            results, held until the next accepted start
//   div_by_zero                    set with done when the divisor was zero
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] q, rem, dvs, trial;
    logic [WIDTH:0] rem_sh, nb;
    logic [CW-1:0] cnt;
    logic [3:0] g4, p4;
    logic [4:0] c4;
    logic cy, co, dbz;
    assign rem_sh = {rem, q[WIDTH-1]};
    assign nb = ~{1'b0, dvs};
    // rem_sh - dvs as rem_sh + ~dvs + 1; co=1 means no borrow
    always_comb begin
        cy = 1'b1;
        g4 = '0;
        p4 = '0;
        c4 = '0;
        trial = '0;
        for (int k = 0; k < WIDTH / 4; k++) begin
            g4 = rem_sh[4*k +: 4] & nb[4*k +: 4];
            p4 = rem_sh[4*k +: 4] ^ nb[4*k +: 4];
            c4[0] = cy;
            c4[1] = g4[0] | (p4[0] & cy);
            c4[2] = g4[1] | (p4[1] & g4[0]) | (&p4[1:0] & cy);
            c4[3] = g4[2] | (p4[2] & g4[1]) | (&p4[2:1] & g4[0]) | (&p4[2:0] & cy);
            c4[4] = g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1]) | (&p4[3:1] & g4[0]) | (&p4 & cy);
            trial[4*k +: 4] = p4 ^ c4[3:0];
            cy = c4[4];
        end
        co = (rem_sh[WIDTH] & nb[WIDTH]) | ((rem_sh[WIDTH] ^ nb[WIDTH]) & cy);
    end
    always_comb begin
        state_nx = (state == IDLE) ? ((start && |divisor) ? RUN : IDLE)
                                   : ((cnt == CW'(1)) ? IDLE : RUN);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                if (|divisor) begin
                    q   <= dividend;
                    rem <= '0;
                    dvs <= divisor;
                    cnt <= CW'(WIDTH);
                    dbz <= 1'b0;
                end else begin
                    q    <= '1;
                    rem  <= dividend;
                    dbz  <= 1'b1;
                    done <= 1'b1;
                end
            end else if (state == RUN) begin
                q    <= {q[WIDTH-2:0], co};
                rem  <= co ? trial : rem_sh[WIDTH-1:0];
                cnt  <= cnt - CW'(1);
                done <= (cnt == CW'(1));
            end
        end
    end
    assign busy        = (state == RUN);
    assign quotient    = q;
    assign remainder   = rem;
    assign div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random self-checking bench for seq_divider
module tb_seq_divider;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
    int ncmp = 0, nerr = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] a, input logic [7:0] b, input int lat0, input bit tail);
        int lat = lat0;
        int nbusy = 0;
        logic [7:0] eq, er;
        eq = (b == 0) ? 8'hFF : a / b;
        er = (b == 0) ? a : a % b;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1);
        check("latency", lat, (b == 0) ? 1 : 9);
        check("busy_cycles", nbusy, (b == 0) ? 0 : 9 - lat0);
        check("busy_at_done", busy, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        if (b != 0) begin
            check("invariant", quotient * b + remainder, a);
            check("rem_lt_div", remainder < b, 1);
        end
        if (tail) begin
            @(negedge clk);
            check("done_width", done, 0);
            check("q_hold", quotient, eq);
            check("r_hold", remainder, er);
        end
    endtask

    initial begin
        logic [7:0] vec_a [10] = '{200, 255, 5, 0, 255, 128, 8'h5A, 9, 1, 254};
        logic [7:0] vec_b [10] = '{7, 1, 9, 3, 255, 2, 0, 3, 0, 127};
        int ndone;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            launch(vec_a[i], vec_b[i]);
            wait_done(vec_a[i], vec_b[i], 1, 1);
        end
        launch(200, 7);
        repeat (3) @(negedge clk);
        dividend = 50;
        divisor  = 5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, 7, 5, 1);
        launch(200, 7);
        wait_done(200, 7, 1, 0);
        launch(100, 10);
        check("b2b_done_fall", done, 0);
        check("b2b_busy_rise", busy, 1);
        wait_done(100, 10, 1, 1);
        launch(200, 7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        ndone = 0;
        repeat (12) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);
        launch(200, 7);
        wait_done(200, 7, 1, 1);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            launch(a, b);
            wait_done(a, b, 1, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
